// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered arbitrating multiplexer.
// Holds the selection-mode encodings and a constant-foldable ceil(log2) helper.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Used only at elaboration time to size channel-index ports.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational rotating-priority encoder built on a double-width masked request vector.
// In fixed mode the rotation base is forced to 0, so the same scan gives ch0-highest priority.
module rr_grant
   import mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              mode,
   output logic [NUM_CH-1:0] gnt_onehot,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              gnt_any
);

   logic [SEL_W-1:0]    base;
   logic [2*NUM_CH-1:0] req_dbl;
   logic [2*NUM_CH-1:0] mask_dbl;
   logic [2*NUM_CH-1:0] masked;

   assign base    = (mode == MODE_RR) ? ptr : '0;
   assign req_dbl = {req, req};

   // Lower copy keeps only positions at or above the base; the upper copy
   // supplies the wrapped-around requests, so the lowest set bit is the winner.
   always_comb begin
      mask_dbl = '0;
      for (int i = 0; i < 2*NUM_CH; i++) begin
         mask_dbl[i] = (i >= int'(base));
      end
   end

   assign masked = req_dbl & mask_dbl;

   always_comb begin
      gnt_any    = 1'b0;
      gnt_idx    = '0;
      gnt_onehot = '0;
      for (int i = 2*NUM_CH-1; i >= 0; i--) begin
         if (masked[i]) begin
            gnt_any = 1'b1;
            gnt_idx = SEL_W'(i % NUM_CH);
         end
      end
      if (gnt_any) begin
         gnt_onehot = NUM_CH'(1) << gnt_idx;
      end
   end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel registered multiplexer with valid/ready handshake and built-in
// fixed-priority or round-robin arbitration; one-cycle latency, full throughput.
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int WIDTH  = 24,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = clog2(NUM_CH)
) (
   input  logic                    Clock,
   input  logic                    ResetN,
   input  logic                    Mode,
   input  logic [NUM_CH-1:0]       InValid,
   input  logic [NUM_CH*WIDTH-1:0] InData,
   output logic [NUM_CH-1:0]       InReady,
   output logic                    OutValid,
   output logic [WIDTH-1:0]        OutData,
   output logic [SEL_W-1:0]        OutSel,
   input  logic                    OutReady
);

   logic [NUM_CH-1:0] gnt_onehot;
   logic [SEL_W-1:0]  gnt_idx;
   logic              gnt_any;
   logic              load;
   logic [WIDTH-1:0]  sel_data;

   logic              vld_p1;
   logic [WIDTH-1:0]  data_p1;
   logic [SEL_W-1:0]  sel_p1;
   logic [SEL_W-1:0]  ptr_p1;

   rr_grant #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_rr_grant (
      .req        (InValid),
      .ptr        (ptr_p1),
      .mode       (Mode),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .gnt_any    (gnt_any)
   );

   // The slot can take a new word when it is empty or being drained this edge.
   assign load     = !vld_p1 || OutReady;
   assign sel_data = InData[int'(gnt_idx)*WIDTH +: WIDTH];

   // Gating with ResetN keeps every producer idle while reset is held.
   assign InReady  = gnt_onehot & {NUM_CH{load & ResetN}};

   // ---- stage p0 -> p1: output register and round-robin pointer ----
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         sel_p1  <= '0;
         ptr_p1  <= '0;
      end else if (load) begin
         if (gnt_any) begin
            vld_p1  <= 1'b1;
            data_p1 <= sel_data;
            sel_p1  <= gnt_idx;
            if (Mode == MODE_RR) begin
               ptr_p1 <= (gnt_idx == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
            end
         end else begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign OutValid = vld_p1;
   assign OutData  = data_p1;
   assign OutSel   = sel_p1;

endmodule
